// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } ctrl_state_e;

  localparam int REG_ZERO        = 0;
  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int WAIT_CNT_W      = 8;

  // Bundle of all pipeline-register hold/bubble controls, MSB first.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_IDLE     = 7'b000_0000;
  localparam ctrl_out_t CTRL_FREEZE   = 7'b110_1011;
  localparam ctrl_out_t CTRL_REDIRECT = 7'b001_0100;
  localparam ctrl_out_t CTRL_LU       = 7'b110_0100;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use comparator: ID source registers against the EX load destination.
module hazard_lu_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_re,
  input  logic              id_rs2_re,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb_ena,
  input  logic              ex_is_load,
  output logic              lu
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_re && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_re && (id_rs2 == ex_rd);
  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign lu = ex_is_load && ex_wb_ena && (ex_rd != ZERO_ADDR) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, redirect flushes, DRAM wait/timeout FSM.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_re,
  input  logic              id_rs2_re,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb_ena,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              dram_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_flush,
  output logic              mem_err,
  output logic              busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  cnt_lu_stall,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_mem_wait
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255) || (CNT_W < 1)) begin : g_param_bad
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
  end

  ctrl_state_e           state;
  ctrl_state_e           state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
  logic                  err_flag;
  logic                  err_flag_nxt;
  logic                  lu;
  logic                  lu_stall;
  logic                  redir_flush;
  ctrl_out_t             outs;

  hazard_lu_detect #(
    .REG_AW (REG_AW)
  ) u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_re  (id_rs1_re),
    .id_rs2_re  (id_rs2_re),
    .ex_rd      (ex_rd),
    .ex_wb_ena  (ex_wb_ena),
    .ex_is_load (ex_is_load),
    .lu         (lu)
  );

  // Next-state, wait counter and pipeline control decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_flag_nxt = err_flag;
    outs         = CTRL_IDLE;
    lu_stall     = 1'b0;
    redir_flush  = 1'b0;
    if (rst) begin
      outs = CTRL_IDLE;
    end else begin
      case (state)
        RUN: begin
          // A pending DRAM access beats a redirect; the held EX replays it afterwards.
          if (mem_req && !dram_ready) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 8'd1;
            outs         = CTRL_FREEZE;
          end else if (ex_redirect) begin
            outs        = CTRL_REDIRECT;
            redir_flush = 1'b1;
          end else if (lu) begin
            outs     = CTRL_LU;
            lu_stall = 1'b1;
          end else begin
            outs = CTRL_IDLE;
          end
        end
        WAIT: begin
          if (dram_ready) begin
            state_nxt = RUN;
            outs      = CTRL_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt    = ERR;
            err_flag_nxt = 1'b1;
            outs         = CTRL_FREEZE;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
            outs         = CTRL_FREEZE;
          end
        end
        ERR: begin
          outs = CTRL_FREEZE;
        end
        default: begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
          outs         = CTRL_IDLE;
        end
      endcase
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_flag <= err_flag_nxt;
    end
  end

  assign pc_stall     = outs.pc_stall;
  assign if_id_stall  = outs.if_id_stall;
  assign if_id_flush  = outs.if_id_flush;
  assign id_ex_stall  = outs.id_ex_stall;
  assign id_ex_flush  = outs.id_ex_flush;
  assign ex_mem_stall = outs.ex_mem_stall;
  assign mem_wb_flush = outs.mem_wb_flush;
  assign mem_err      = err_flag && !rst;
  assign busy         = (state == WAIT) && !rst;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cyc_cnt;

  // Free-running event counters; natural wrap at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt       <= '0;
      flush_cnt    <= '0;
      wait_cyc_cnt <= '0;
    end else begin
      lu_cnt       <= lu_cnt + CNT_W'(lu_stall);
      flush_cnt    <= flush_cnt + CNT_W'(redir_flush);
      wait_cyc_cnt <= wait_cyc_cnt + CNT_W'((state == WAIT) || (state == ERR));
    end
  end

  assign cnt_lu_stall = rst ? '0 : lu_cnt;
  assign cnt_flush    = rst ? '0 : flush_cnt;
  assign cnt_mem_wait = rst ? '0 : wait_cyc_cnt;
`else
  logic unused_perf;
  assign unused_perf = lu_stall ^ redir_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int TMO = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst, id_rs1_re, id_rs2_re, ex_wb_ena, ex_is_load, ex_redirect, mem_req, dram_ready;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush, mem_err, busy;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] cnt_lu_stall, cnt_flush, cnt_mem_wait;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .ex_rd(ex_rd), .ex_wb_ena(ex_wb_ena), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .dram_ready(dram_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .busy(busy)
`ifdef HAZARD_PERF_EN
    , .cnt_lu_stall(cnt_lu_stall), .cnt_flush(cnt_flush), .cnt_mem_wait(cnt_mem_wait)
`endif
  );

  typedef struct {
    logic [8:0]  o;
    logic [31:0] c_lu;
    logic [31:0] c_fl;
    logic [31:0] c_wt;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model state: 0 run, 1 wait, 2 err
  int m_state = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;
  int m_lu = 0, m_fl = 0, m_wt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input bit r, input int rs1, input bit re1,
                       input int rs2, input bit re2, input int rd, input bit wb,
                       input bit ld, input bit redir, input bit mreq, input bit rdy);
    exp_t e;
    exp_t g;
    bit   luh;
    logic [6:0] c;
    @(negedge clk);
    rst = r; id_rs1 = AW'(rs1); id_rs1_re = re1; id_rs2 = AW'(rs2); id_rs2_re = re2;
    ex_rd = AW'(rd); ex_wb_ena = wb; ex_is_load = ld; ex_redirect = redir;
    mem_req = mreq; dram_ready = rdy;
    luh = ld && wb && (rd != 0) && ((re1 && rs1 == rd) || (re2 && rs2 == rd));
    c = 7'b000_0000;
    if (!r) begin
      if (m_state == 0) begin
        if (mreq && !rdy)  c = 7'b110_1011;
        else if (redir)    c = 7'b001_0100;
        else if (luh)      c = 7'b110_0100;
      end else if (m_state == 1) begin
        if (!rdy) c = 7'b110_1011;
      end else begin
        c = 7'b110_1011;
      end
    end
    e.o    = {c, (m_err && !r), (m_state == 1 && !r)};
    e.c_lu = r ? 32'd0 : 32'(m_lu);
    e.c_fl = r ? 32'd0 : 32'(m_fl);
    e.c_wt = r ? 32'd0 : 32'(m_wt);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check({tag, ".outs"}, 32'({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                               ex_mem_stall, mem_wb_flush, mem_err, busy}), 32'(g.o));
`ifdef HAZARD_PERF_EN
    check({tag, ".cnt_lu"}, cnt_lu_stall, g.c_lu);
    check({tag, ".cnt_fl"}, cnt_flush, g.c_fl);
    check({tag, ".cnt_wt"}, cnt_mem_wait, g.c_wt);
`endif
    // advance the model to the state after the coming rising edge
    if (r) begin
      m_state = 0; m_cnt = 0; m_err = 1'b0; m_lu = 0; m_fl = 0; m_wt = 0;
    end else begin
      if (m_state != 0) m_wt++;
      if (m_state == 0) begin
        if (mreq && !rdy) begin m_state = 1; m_cnt = 1; end
        else if (redir) m_fl++;
        else if (luh) m_lu++;
      end else if (m_state == 1) begin
        if (rdy) m_state = 0;
        else if (m_cnt == TMO - 1) begin m_state = 2; m_err = 1'b1; end
        else m_cnt++;
      end
    end
  endtask

  task automatic idle(input string tag);
    apply(tag, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rs1_re = 1'b0; id_rs2_re = 1'b0; ex_rd = '0;
    ex_wb_ena = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; dram_ready = 1'b0;

    // reset with a live hazard and pending DRAM request on the inputs
    apply("rst_hold", 1'b1, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("idle");
    apply("lu_rs1",  1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("lu_x0",   1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("lu_nore", 1'b0, 5, 1'b0, 3, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("redir_lu", 1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply("lu_rs2",  1'b0, 1, 1'b1, 7, 1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("mem_hit", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // DRAM wait: entry plus two waiting cycles, then ready; redirect during freeze is ignored
    apply("wait0", 1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply("wait1", 1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply("wait2", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("wait_rdy", 1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle("run_after");
`ifdef HAZARD_PERF_EN
    check("perf_lu", cnt_lu_stall, 32'd2);
    check("perf_flush", cnt_flush, 32'd1);
    check("perf_wait", cnt_mem_wait, 32'd3);
`endif
    // timeout: four wait cycles with no ready, then frozen in error until reset
    for (int i = 0; i < 7; i++)
      apply("tmo", 1'b0, 2, 1'b1, 0, 1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply("err_rdy", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    apply("err_rst", 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("post_err");
    // reset in the middle of a wait
    apply("mw0", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("mw1", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("mw_rst", 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("mw_after");

    for (int i = 0; i < 600; i++) begin
      apply("rand", ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
